booth_mult_dispatch: RTL and testbench

//  Upstream dispatcher for booth_mult_16bit. Accepts signed 16-bit operand pairs
//  on a valid/ready stream and buffers them in a small FIFO. Issues each pair to
//  the multiplier with a one-cycle start pulse and waits for done. Returns the
//  32-bit product on a valid/ready result stream, with a timeout error flag.

---
 rtl/booth_mult_dispatch_if.sv | 31 +++
 rtl/booth_mult_dispatch.sv | 136 +++++++++++++
 tb/tb_booth_mult_dispatch.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_dispatch_if.sv
// Handshake bundle between booth_mult_dispatch and its neighbours.
//   in_*   : operand stream (valid/ready), signed 16-bit A and B
//   mult_* : start/operands to the multiplier, product/done back
//   out_*  : result stream (valid/ready), signed 32-bit product + timeout flag
// slave  : the dispatcher side.
// master : the environment side (upstream source, multiplier, downstream sink).
interface booth_mult_dispatch_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        mult_start;
    logic [15:0] mult_a;
    logic [15:0] mult_b;
    logic [31:0] mult_p;
    logic        mult_done;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_p;
    logic        out_err;

    modport master (
        output in_valid, in_a, in_b, mult_p, mult_done, out_ready,
        input  in_ready, mult_start, mult_a, mult_b, out_valid, out_p, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, mult_p, mult_done, out_ready,
        output in_ready, mult_start, mult_a, mult_b, out_valid, out_p, out_err
    );
endinterface

// File: rtl/booth_mult_dispatch.sv
// Upstream dispatcher for booth_mult_16bit. Buffers operand pairs in a small
// FIFO, issues one pair at a time with a single-cycle start pulse, waits for
// done (or a timeout), and returns the product on a valid/ready stream.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : booth_mult_dispatch_if.slave (operand, multiplier, result)
//   busy       : FIFO non-empty or an operation in progress
//   fifo_count : number of queued operand pairs
module booth_mult_dispatch #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 200
) (
    input  logic                              clk,
    input  logic                              rst,
    booth_mult_dispatch_if.slave              bus,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t         state;
    state_t         state_nxt;

    logic [15:0]    mem_a [FIFO_DEPTH];
    logic [15:0]    mem_b [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [TW-1:0]  timer;
    logic           push;
    logic           pop;
    logic           timed_out;

    // Ready depends on count only, so a full FIFO stays not-ready even while popping.
    assign bus.in_ready = !rst && (count < CW'(FIFO_DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign timed_out    = (timer == TW'(TIMEOUT_CYC - 1));
    assign busy         = (state != IDLE) || (count != '0);
    assign fifo_count   = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pop            = 1'b0;
        bus.mult_start = 1'b0;
        bus.out_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            // mult_done is deliberately not looked at here: it may be stale.
            ISSUE: begin
                bus.mult_start = 1'b1;
                state_nxt      = WAIT;
            end
            WAIT: begin
                if (bus.mult_done || timed_out) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO storage has no reset; flushing is done through the pointers/count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= bus.in_a;
            mem_b[wr_ptr] <= bus.in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            timer       <= '0;
            bus.mult_a  <= '0;
            bus.mult_b  <= '0;
            bus.out_p   <= '0;
            bus.out_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                bus.mult_a <= mem_a[rd_ptr];
                bus.mult_b <= mem_b[rd_ptr];
                rd_ptr     <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            case (state)
                ISSUE: timer <= '0;
                WAIT: begin
                    // Done takes priority over a coincident timeout.
                    if (bus.mult_done) begin
                        bus.out_p   <= bus.mult_p;
                        bus.out_err <= 1'b0;
                    end else if (timed_out) begin
                        bus.out_p   <= '0;
                        bus.out_err <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mult_dispatch.sv
module tb_booth_mult_dispatch;
    logic       clk;
    logic       rst;
    logic       busy;
    logic [2:0] fifo_count;

    booth_mult_dispatch_if bus();

    booth_mult_dispatch #(
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (200)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] p;
        logic        err;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        logic        err;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   starts = 0;
    int   results = 0;
    int   mode = 0;       // 0: done after 17 cycles, 1: never done, 2: done held high between ops
    logic prev_start = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, $signed(act), act, $signed(req), req);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Behavioural multiplier, acting 1 time unit after each rising edge.
    initial begin : mult_model
        int          cnt;
        logic [31:0] prod;
        logic        drop;
        logic [31:0] ea;
        logic [31:0] eb;
        cnt  = 0;
        prod = '0;
        drop = 1'b0;
        bus.mult_done = 1'b0;
        bus.mult_p    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (drop) begin
                bus.mult_done = 1'b0;
                drop = 1'b0;
            end else if (mode != 2) begin
                bus.mult_done = 1'b0;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.mult_done = 1'b1;
                    bus.mult_p    = prod;
                end
            end
            if (bus.mult_start) begin
                ea   = {{16{bus.mult_a[15]}}, bus.mult_a};
                eb   = {{16{bus.mult_b[15]}}, bus.mult_b};
                prod = $signed(ea) * $signed(eb);
                cnt  = (mode == 1) ? 0 : 17;
                // Keep a stale done visible through ISSUE, drop it in WAIT.
                if (mode == 2 && bus.mult_done) drop = 1'b1;
            end
        end
    end

    // Result monitor and scoreboard pop.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mult_start) begin
                check("start_single_cycle", 32'(prev_start), 32'd0);
                starts++;
            end
            prev_start = bus.mult_start;
            if (bus.out_valid && bus.out_ready) begin
                results++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got out_p=%0d out_err=%0b, expected no result", $signed(bus.out_p), bus.out_err);
                end else begin
                    e = sb.pop_front();
                    check("out_p", bus.out_p, e.p);
                    check("out_err", 32'(bus.out_err), 32'(e.err));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [31:0] p, input logic e);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        @(negedge clk);
        while (!bus.in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            fail_timeout("send_in_ready");
        end else begin
            sb.push_back('{p: p, err: e});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || busy || bus.out_valid) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || busy || bus.out_valid) fail_timeout("wait_idle");
        @(posedge clk);
        #1;
    endtask

    // Returns at the negedge of the ISSUE cycle.
    task automatic wait_start(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.mult_start && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!bus.mult_start) fail_timeout("wait_start");
    endtask

    task automatic wait_out_valid(input int bound, output int cyc);
        cyc = 0;
        @(negedge clk);
        cyc++;
        while (!bus.out_valid && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.out_valid) fail_timeout("wait_out_valid");
    endtask

    initial begin : main
        vec_t        vecs[6];
        vec_t        hold_vecs[3];
        int          s0;
        int          r0;
        int          cyc;
        int          ov;
        logic [31:0] held_p;

        vecs[0] = '{a: 16'd3,                b: 16'd2,                p: 32'd6,                 err: 1'b0};
        vecs[1] = '{a: 16'd3,                b: 16'd2,                p: 32'd6,                 err: 1'b0};
        vecs[2] = '{a: 16'd10,               b: 16'(-4),              p: 32'(-40),              err: 1'b0};
        vecs[3] = '{a: 16'(-5),              b: 16'(-5),              p: 32'd25,                err: 1'b0};
        vecs[4] = '{a: 16'h7FFF,             b: 16'h8000,             p: 32'(-1073709056),      err: 1'b0};
        vecs[5] = '{a: 16'd20,               b: 16'd0,                p: 32'd0,                 err: 1'b0};
        hold_vecs[0] = '{a: 16'd4,           b: 16'd5,                p: 32'd20,                err: 1'b0};
        hold_vecs[1] = '{a: 16'(-7),         b: 16'd9,                p: 32'(-63),              err: 1'b0};
        hold_vecs[2] = '{a: 16'd100,         b: 16'(-100),            p: 32'(-10000),           err: 1'b0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",   32'(bus.in_ready),   32'd0);
        check("rst_busy",       32'(busy),           32'd0);
        check("rst_fifo_count", 32'(fifo_count),     32'd0);
        check("rst_out_valid",  32'(bus.out_valid),  32'd0);
        check("rst_mult_start", 32'(bus.mult_start), 32'd0);
        check("rst_out_p",      bus.out_p,           32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // 1: single op, exactly one start pulse
        s0 = starts;
        send(vecs[0].a, vecs[0].b, vecs[0].p, vecs[0].err);
        wait_idle(200);
        check("single_start_count", 32'(starts - s0), 32'd1);

        // 2: burst, results in order, FIFO fills to 4 and stops accepting
        for (int i = 1; i < 6; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].err);
        end
        @(negedge clk);
        check("burst_fifo_full",     32'(fifo_count),   32'd4);
        check("burst_in_ready_full", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        wait_idle(500);

        // 3: back-pressure holds the result and blocks the next issue
        bus.out_ready = 1'b0;
        send(16'd11, 16'd3, 32'd33, 1'b0);
        send(16'd2,  16'd2, 32'd4,  1'b0);
        wait_out_valid(100, cyc);
        held_p = bus.out_p;
        s0 = starts;
        repeat (20) begin
            @(negedge clk);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_out_p",     bus.out_p,          held_p);
        end
        check("stall_no_start", 32'(starts - s0), 32'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_idle(200);

        // 4: timeout after 200 WAIT cycles, then a normal op recovers
        mode = 1;
        send(16'd1, 16'd1, 32'd0, 1'b1);
        wait_start(50);
        wait_out_valid(400, cyc);
        check("timeout_latency", 32'(cyc), 32'd201);
        wait_idle(50);
        mode = 0;
        send(16'd7, 16'(-3), 32'(-21), 1'b0);
        wait_idle(200);

        // 5: reset during WAIT aborts the op; the late done produces nothing
        send(16'd5, 16'd6, 32'd30, 1'b0);
        wait_start(50);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        check("midrst_in_ready",   32'(bus.in_ready),   32'd0);
        check("midrst_out_valid",  32'(bus.out_valid),  32'd0);
        check("midrst_out_p",      bus.out_p,           32'd0);
        check("midrst_out_err",    32'(bus.out_err),    32'd0);
        check("midrst_mult_start", 32'(bus.mult_start), 32'd0);
        check("midrst_mult_a",     32'(bus.mult_a),     32'd0);
        check("midrst_mult_b",     32'(bus.mult_b),     32'd0);
        check("midrst_busy",       32'(busy),           32'd0);
        check("midrst_fifo_count", 32'(fifo_count),     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        r0 = results;
        ov = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) ov++;
        end
        check("late_done_no_valid",  32'(ov),           32'd0);
        check("late_done_no_result", 32'(results - r0), 32'd0);
        check("late_done_busy",      32'(busy),         32'd0);
        @(posedge clk);
        #1;

        // 6: stale done held high across ISSUE must be ignored
        mode = 2;
        for (int i = 0; i < 3; i++) begin
            send(hold_vecs[i].a, hold_vecs[i].b, hold_vecs[i].p, hold_vecs[i].err);
        end
        wait_idle(300);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
